// File: rtl/div_reconstruct.sv
// Rebuilds a divider's dividend as recon = q*d + r and flags whether the triple is a legal divider output.
// Latency: done pulses WIDTH+1 edges after start is accepted; one operation in flight at a time.
// Backpressure: start is accepted only while busy=0; start during busy is dropped, not queued.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, is_signed         request strobe and operand mode (captured at accept)
//   q_in, d_in, r_in         quotient, divisor, remainder (WIDTH bits)
//   busy, done               operation in flight / one-cycle result strobe
//   product, recon           q*d and q*d + r (2*WIDTH bits), held until the next result
//   recon_fits, consistent   recon fits a WIDTH-bit dividend / triple is a valid divider output
module div_reconstruct #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   q_in,
   input  logic [WIDTH-1:0]   d_in,
   input  logic [WIDTH-1:0]   r_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [2*WIDTH-1:0] recon,
   output logic               recon_fits,
   output logic               consistent
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

   state_t          state_q, state_d;
   logic            sgn_q, sgn_d;
   logic            neg_q, neg_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [PW-1:0]   product_q, product_d;
   logic [PW-1:0]   recon_q, recon_d;
   logic            fits_q, fits_d;
   logic            cons_q, cons_d;
   logic            done_q, done_d;

   // Magnitude in WIDTH bits; the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic s, input logic [WIDTH-1:0] x);
      return (s && x[WIDTH-1]) ? -x : x;
   endfunction

   logic [PW-1:0]    addend;
   logic [PW-1:0]    prod_fix;
   logic [PW-1:0]    r_ext;
   logic [PW-1:0]    recon_fix;
   logic             fits_fix;
   logic             sign_ok;
   logic             cons_fix;

   always_comb begin
      addend    = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
      prod_fix  = neg_q ? -acc_q : acc_q;
      r_ext     = {{WIDTH{sgn_q & r_q[WIDTH-1]}}, r_q};
      recon_fix = prod_fix + r_ext;
      // Signed fit: the top WIDTH+1 bits must all be copies of the sign.
      fits_fix  = sgn_q ? ((&recon_fix[PW-1:WIDTH-1]) | ~(|recon_fix[PW-1:WIDTH-1]))
                        : ~(|recon_fix[PW-1:WIDTH]);
      // Truncating division gives the remainder the dividend's sign (or zero).
      sign_ok   = !sgn_q || (r_q == '0) || (r_q[WIDTH-1] == recon_fix[PW-1]);
      cons_fix  = (d_q != '0) && (mag(sgn_q, r_q) < mag(sgn_q, d_q)) && sign_ok && fits_fix;
   end

   always_comb begin
      state_d   = state_q;
      sgn_d     = sgn_q;
      neg_d     = neg_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      d_d       = d_q;
      r_d       = r_q;
      product_d = product_q;
      recon_d   = recon_q;
      fits_d    = fits_q;
      cons_d    = cons_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               sgn_d    = is_signed;
               neg_d    = is_signed & (q_in[WIDTH-1] ^ d_in[WIDTH-1]);
               mplier_d = mag(is_signed, q_in);
               mcand_d  = mag(is_signed, d_in);
               d_d      = d_in;
               r_d      = r_in;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = MUL;
            end
         end
         MUL: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + addend;
            end
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            product_d = prod_fix;
            recon_d   = recon_fix;
            fits_d    = fits_fix;
            cons_d    = cons_fix;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sgn_q     <= 1'b0;
         neg_q     <= 1'b0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         d_q       <= '0;
         r_q       <= '0;
         product_q <= '0;
         recon_q   <= '0;
         fits_q    <= 1'b0;
         cons_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sgn_q     <= sgn_d;
         neg_q     <= neg_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         d_q       <= d_d;
         r_q       <= r_d;
         product_q <= product_d;
         recon_q   <= recon_d;
         fits_q    <= fits_d;
         cons_q    <= cons_d;
         done_q    <= done_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign product    = product_q;
   assign recon      = recon_q;
   assign recon_fits = fits_q;
   assign consistent = cons_q;

endmodule
